uart_rx_os: RTL and testbench

// Oversampling UART receiver; the receive end of the 8N1 serial link our UART_tx drives.

---
 rtl/uart_rx_os_if.sv | 31 +++
 rtl/uart_rx_os.sv | 132 +++++++++++++
 tb/tb_uart_rx_os.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_os_if.sv
// Receive-side bundle of the oversampling UART: serial line in, byte handshake and flags out.
// The receiver uses the master modport; the consuming logic uses the slave modport.
interface uart_rx_os_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        input  rx,
        input  rx_ready,
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        output busy
    );

    modport slave (
        output rx,
        output rx_ready,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  busy
    );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver on the system clock: samples each bit at its centre and
// hands bytes out on a valid/ready handshake with framing-error and overrun pulses.
module uart_rx_os #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_rx_os_if.master bus
);
    localparam int unsigned DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned TW  = $clog2(DIV) + 1;
    localparam int unsigned OW  = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e      r_state, w_state_d;
    logic [TW-1:0] r_tick_cnt;
    logic [OW-1:0] r_os_cnt, w_os_cnt_d;
    logic [3:0]  r_bit_cnt, w_bit_cnt_d;
    logic [7:0]  r_shift, w_shift_d;
    logic        r_sync1, r_rx_s;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid, r_frame_err, r_overrun;
    logic        w_tick, w_commit, w_frame_err, w_os_last;

    assign w_tick    = (r_tick_cnt == TW'(DIV - 1));
    assign w_os_last = (r_os_cnt == OW'(OVERSAMPLE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_sync1    <= 1'b1;
            r_rx_s     <= 1'b1;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_sync1    <= bus.rx;
            r_rx_s     <= r_sync1;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_os_cnt_d  = r_os_cnt;
        w_bit_cnt_d = r_bit_cnt;
        w_shift_d   = r_shift;
        w_commit    = 1'b0;
        w_frame_err = 1'b0;
        if (w_tick) begin
            w_os_cnt_d = w_os_last ? '0 : r_os_cnt + 1'b1;
            unique case (r_state)
                StIdle: begin
                    if (!r_rx_s) w_state_d = StStart;
                end
                StStart: begin
                    // Half a bit in: a line that is high again was only a glitch
                    if (r_os_cnt == OW'(OVERSAMPLE / 2 - 1)) begin
                        if (!r_rx_s) begin
                            w_state_d   = StData;
                            w_bit_cnt_d = 4'd0;
                        end else begin
                            w_state_d = StIdle;
                        end
                    end
                end
                StData: begin
                    if (w_os_last) begin
                        w_shift_d   = {r_rx_s, r_shift[7:1]};
                        w_bit_cnt_d = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) w_state_d = StStop;
                    end
                end
                StStop: begin
                    if (w_os_last) begin
                        if (r_rx_s) begin
                            w_commit  = 1'b1;
                            w_state_d = StIdle;
                        end else begin
                            w_frame_err = 1'b1;
                            w_state_d   = StBreak;
                        end
                    end
                end
                StBreak: begin
                    if (r_rx_s) w_state_d = StIdle;
                end
                default: w_state_d = StIdle;
            endcase
            if (w_state_d != r_state) w_os_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_os_cnt  <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_d;
            r_os_cnt  <= w_os_cnt_d;
            r_bit_cnt <= w_bit_cnt_d;
            r_shift   <= w_shift_d;
        end
    end

    // A commit coinciding with an accept reloads the holding register without a gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            r_overrun   <= w_commit & r_rx_valid & ~bus.rx_ready;
            if (w_commit && (!r_rx_valid || bus.rx_ready)) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && bus.rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;
    assign bus.busy      = (r_state != StIdle);
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at 16 clk per bit; accepted bytes are checked against a
// scoreboard queue filled as frames are driven.
module tb_uart_rx_os;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_rx_os_if bus ();

    uart_rx_os #(
        .CLK_FREQ   (1600),
        .BAUD_RATE  (100),
        .OVERSAMPLE (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid_cyc = 0;
    int n_ferr = 0;
    int n_ovr = 0;
    logic [7:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expected);
        n_checks++;
        assert (obs === expected) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expected);
        end
    endtask

    // Monitor samples 1 ns after the falling edge, after stimulus for that edge has settled
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (bus.rx_valid)  n_valid_cyc++;
            if (bus.frame_err) n_ferr++;
            if (bus.overrun)   n_ovr++;
            if (bus.rx_valid && bus.rx_ready) begin
                n_checks++;
                assert (sb_q.size() != 0) else begin
                    n_errors++;
                    $error("FAIL sb_unexpected observed=0x%0h expected=none", bus.rx_data);
                end
                if (sb_q.size() != 0) check("sb_rx_data", 32'(bus.rx_data), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bus.rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (16) @(negedge clk);
        end
        bus.rx = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic wait_not_busy(input int budget, output logic found);
        found = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!bus.busy) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int   v0, f0, o0;
        logic seen_busy, found;
        logic [7:0] part;

        bus.rx       = 1'b1;
        bus.rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rx_data",   32'(bus.rx_data),   32'h00);
        check("rst_rx_valid",  32'(bus.rx_valid),  32'h0);
        check("rst_frame_err", 32'(bus.frame_err), 32'h0);
        check("rst_overrun",   32'(bus.overrun),   32'h0);
        check("rst_busy",      32'(bus.busy),      32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: single byte, consumer always ready
        bus.rx_ready = 1'b1;
        v0 = n_valid_cyc; f0 = n_ferr; o0 = n_ovr;
        sb_q.push_back(8'hA5);
        send_byte(8'hA5);
        repeat (20) @(negedge clk);
        check("t1_valid_cycles", 32'(n_valid_cyc - v0), 32'd1);
        check("t1_frame_err",    32'(n_ferr - f0),      32'd0);
        check("t1_overrun",      32'(n_ovr - o0),       32'd0);
        check("t1_sb_drained",   32'(sb_q.size()),      32'd0);
        check("t1_busy",         32'(bus.busy),         32'h0);

        // 2: 4-clk low glitch on an idle line
        v0 = n_valid_cyc; f0 = n_ferr;
        seen_busy = 1'b0;
        bus.rx = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen_busy |= bus.busy;
        end
        bus.rx = 1'b1;
        wait_not_busy(8, found);
        check("t2_busy_seen",    32'(seen_busy), 32'h1);
        check("t2_busy_cleared", 32'(found),     32'h1);
        repeat (16) @(negedge clk);
        check("t2_no_valid",     32'(n_valid_cyc - v0), 32'd0);
        check("t2_no_frame_err", 32'(n_ferr - f0),      32'd0);

        // 3: line held low for 20 bit times
        v0 = n_valid_cyc; f0 = n_ferr;
        bus.rx = 1'b0;
        repeat (320) @(negedge clk);
        check("t3_busy_held",  32'(bus.busy),          32'h1);
        check("t3_frame_errs", 32'(n_ferr - f0),       32'd1);
        check("t3_no_valid",   32'(n_valid_cyc - v0),  32'd0);
        bus.rx = 1'b1;
        wait_not_busy(8, found);
        check("t3_busy_released", 32'(found), 32'h1);
        repeat (32) @(negedge clk);

        // 4: consumer stalled, second byte overruns
        bus.rx_ready = 1'b0;
        f0 = n_ferr; o0 = n_ovr;
        sb_q.push_back(8'h12);
        send_byte(8'h12);
        send_byte(8'h34);
        repeat (20) @(negedge clk);
        check("t4_valid_held",  32'(bus.rx_valid),  32'h1);
        check("t4_data_held",   32'(bus.rx_data),   32'h12);
        check("t4_overrun",     32'(n_ovr - o0),    32'd1);
        check("t4_frame_err",   32'(n_ferr - f0),   32'd0);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
        check("t4_valid_dropped", 32'(bus.rx_valid), 32'h0);
        check("t4_data_kept",     32'(bus.rx_data),  32'h12);
        check("t4_sb_drained",    32'(sb_q.size()),  32'd0);

        // 5: asynchronous reset during the 4th data bit
        part = 8'h3C;
        bus.rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.rx = part[i];
            repeat (16) @(negedge clk);
        end
        bus.rx = part[3];
        repeat (8) @(negedge clk);
        check("t5_busy_before_reset", 32'(bus.busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_rx_data",   32'(bus.rx_data),   32'h00);
        check("t5_rst_rx_valid",  32'(bus.rx_valid),  32'h0);
        check("t5_rst_frame_err", 32'(bus.frame_err), 32'h0);
        check("t5_rst_overrun",   32'(bus.overrun),   32'h0);
        check("t5_rst_busy",      32'(bus.busy),      32'h0);
        @(negedge clk);
        bus.rx = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (32) @(negedge clk);
        bus.rx_ready = 1'b1;
        v0 = n_valid_cyc; f0 = n_ferr;
        sb_q.push_back(8'h5A);
        send_byte(8'h5A);
        repeat (20) @(negedge clk);
        check("t5_valid_cycles", 32'(n_valid_cyc - v0), 32'd1);
        check("t5_frame_err",    32'(n_ferr - f0),      32'd0);
        check("t5_sb_drained",   32'(sb_q.size()),      32'd0);

        // 6: back-to-back frames, single stop bit each
        v0 = n_valid_cyc; f0 = n_ferr; o0 = n_ovr;
        sb_q.push_back(8'h00);
        sb_q.push_back(8'hFF);
        send_byte(8'h00);
        send_byte(8'hFF);
        repeat (20) @(negedge clk);
        check("t6_valid_cycles", 32'(n_valid_cyc - v0), 32'd2);
        check("t6_frame_err",    32'(n_ferr - f0),      32'd0);
        check("t6_overrun",      32'(n_ovr - o0),       32'd0);
        check("t6_sb_drained",   32'(sb_q.size()),      32'd0);
        check("t6_last_data",    32'(bus.rx_data),      32'hFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
